// File: rtl/axi_eth_v1_wrapper_if.sv
// AXI4-Lite slave bundle for axi_eth_v1_wrapper (8-bit address, 32-bit data).
// master: the bus initiator (testbench / interconnect)
// slave : the register block
interface axi_eth_v1_wrapper_if;
  logic [7:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [7:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_eth_v1_wrapper.sv
// Four-port SGMII-style line wrapper with an AXI4-Lite register block.
// Each port transmits a 10-bit TX_WORD LSB first (shared bit counter), can be
// switched to line loopback, and tracks receive sync by matching the last ten
// received bits against the active TX_WORD.
// Ports:
//   aclk, arst                   clock, asynchronous active-high reset
//   s_axi                        AXI4-Lite slave (register map at addr[7:2])
//   sgmii_port_N_rxp/rxn         serial receive lanes (asynchronous inputs)
//   sgmii_port_N_txp/txn         serial transmit lanes (registered)
//   reset_port_N_n               PHY resets (PORT_RESET_N)
//   phy_gpio_o/_t/_i             GPIO output / tristate (1 = input) / input
//   BT_ctsn, BT_rtsn             UART flow control
module axi_eth_v1_wrapper (
  input  logic                      aclk,
  input  logic                      arst,
  axi_eth_v1_wrapper_if.slave       s_axi,
  input  logic                      sgmii_port_0_rxp,
  input  logic                      sgmii_port_0_rxn,
  input  logic                      sgmii_port_1_rxp,
  input  logic                      sgmii_port_1_rxn,
  input  logic                      sgmii_port_2_rxp,
  input  logic                      sgmii_port_2_rxn,
  input  logic                      sgmii_port_3_rxp,
  input  logic                      sgmii_port_3_rxn,
  output logic                      sgmii_port_0_txp,
  output logic                      sgmii_port_0_txn,
  output logic                      sgmii_port_1_txp,
  output logic                      sgmii_port_1_txn,
  output logic                      sgmii_port_2_txp,
  output logic                      sgmii_port_2_txn,
  output logic                      sgmii_port_3_txp,
  output logic                      sgmii_port_3_txn,
  output logic                      reset_port_0_n,
  output logic                      reset_port_1_n,
  output logic                      reset_port_2_n,
  output logic                      reset_port_3_n,
  output logic [7:0]                phy_gpio_o,
  output logic [7:0]                phy_gpio_t,
  input  logic [7:0]                phy_gpio_i,
  input  logic                      BT_ctsn,
  output logic                      BT_rtsn
);
  localparam int          NUM_LANES = 4;
  localparam logic [31:0] ID_VAL    = 32'h4554_0001;
  localparam logic [1:0]  RESP_OK   = 2'b00;
  localparam logic [1:0]  RESP_ERR  = 2'b10;

  // ---------------- registers ----------------
  logic [3:0]  lb_n_q, prst_n_q;
  logic [9:0]  tx_word_q, tx_act_q;
  logic [7:0]  gpo_q, gpt_q;
  logic        uart_q, rtsn_q;
  logic [3:0]  cnt_q;

  // two-flop synchronizers
  logic [NUM_LANES-1:0] rxp_s1_q, rxp_s2_q, rxn_s1_q, rxn_s2_q;
  logic [7:0]           gpi_s1_q, gpi_s2_q;
  logic                 cts_s1_q, cts_s2_q;

  // AXI state
  logic        awready_q, bvalid_q, arready_q, rvalid_q;
  logic [1:0]  bresp_q, rresp_q;
  logic [31:0] rdata_q;

  logic [NUM_LANES-1:0] rx_raw_p, rx_raw_n, txp_w, txn_w, rx_sync;
  logic                 tx_bit;

  assign rx_raw_p = {sgmii_port_3_rxp, sgmii_port_2_rxp, sgmii_port_1_rxp, sgmii_port_0_rxp};
  assign rx_raw_n = {sgmii_port_3_rxn, sgmii_port_2_rxn, sgmii_port_1_rxn, sgmii_port_0_rxn};

  // ---------------- register read view ----------------
  logic [15:0][31:0] regs_v;
  always_comb begin
    regs_v    = '0;
    regs_v[0] = ID_VAL;
    regs_v[1] = {23'b0, cts_s2_q, prst_n_q, rx_sync};
    regs_v[2] = {28'b0, lb_n_q};
    regs_v[3] = {28'b0, prst_n_q};
    regs_v[4] = {22'b0, tx_word_q};
    regs_v[5] = {24'b0, gpo_q};
    regs_v[6] = {24'b0, gpt_q};
    regs_v[7] = {24'b0, gpi_s2_q};
    regs_v[8] = {31'b0, uart_q};
  end

  logic [5:0]  aw_idx, ar_idx;
  logic        aw_rw, ar_map, wr_hs, ar_hs;
  logic [31:0] wmask, wmerge;

  assign aw_idx = s_axi.awaddr[7:2];
  assign ar_idx = s_axi.araddr[7:2];
  assign aw_rw  = aw_idx inside {6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd8};
  assign ar_map = (ar_idx <= 6'd8);
  assign wr_hs  = awready_q & s_axi.awvalid & s_axi.wvalid;
  assign ar_hs  = arready_q & s_axi.arvalid;
  assign wmask  = {{8{s_axi.wstrb[3]}}, {8{s_axi.wstrb[2]}},
                   {8{s_axi.wstrb[1]}}, {8{s_axi.wstrb[0]}}};
  // byte-lane merge of write data into the current register contents
  assign wmerge = (regs_v[aw_idx[3:0]] & ~wmask) | (s_axi.wdata & wmask);

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{s_axi.awaddr[1:0], s_axi.araddr[1:0]};

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      lb_n_q    <= 4'hF;
      prst_n_q  <= 4'h0;
      tx_word_q <= 10'h0FA;
      tx_act_q  <= 10'h0FA;
      gpo_q     <= 8'h00;
      gpt_q     <= 8'hFF;
      uart_q    <= 1'b1;
      rtsn_q    <= 1'b1;
      cnt_q     <= 4'd0;
      rxp_s1_q  <= '0;
      rxp_s2_q  <= '0;
      rxn_s1_q  <= '0;
      rxn_s2_q  <= '0;
      gpi_s1_q  <= '0;
      gpi_s2_q  <= '0;
      cts_s1_q  <= 1'b0;
      cts_s2_q  <= 1'b0;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OK;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OK;
      rdata_q   <= '0;
    end else begin
      rxp_s1_q <= rx_raw_p;
      rxp_s2_q <= rxp_s1_q;
      rxn_s1_q <= rx_raw_n;
      rxn_s2_q <= rxn_s1_q;
      gpi_s1_q <= phy_gpio_i;
      gpi_s2_q <= gpi_s1_q;
      cts_s1_q <= BT_ctsn;
      cts_s2_q <= cts_s1_q;
      rtsn_q   <= uart_q | cts_s2_q;

      // shared bit counter; a new TX_WORD only goes live on a word boundary
      if (cnt_q == 4'd9) begin
        cnt_q    <= 4'd0;
        tx_act_q <= tx_word_q;
      end else begin
        cnt_q <= cnt_q + 4'd1;
      end

      // write channel: ready pulses one cycle, never while a response is pending
      awready_q <= s_axi.awvalid & s_axi.wvalid & ~bvalid_q & ~awready_q;
      if (wr_hs) begin
        bvalid_q <= 1'b1;
        bresp_q  <= aw_rw ? RESP_OK : RESP_ERR;
        if (aw_rw) begin
          case (aw_idx[3:0])
            4'd2:    lb_n_q    <= wmerge[3:0];
            4'd3:    prst_n_q  <= wmerge[3:0];
            4'd4:    tx_word_q <= wmerge[9:0];
            4'd5:    gpo_q     <= wmerge[7:0];
            4'd6:    gpt_q     <= wmerge[7:0];
            4'd8:    uart_q    <= wmerge[0];
            default: ;
          endcase
        end
      end else if (bvalid_q && s_axi.bready) begin
        bvalid_q <= 1'b0;
      end

      // read channel
      arready_q <= s_axi.arvalid & ~rvalid_q & ~arready_q;
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= ar_map ? regs_v[ar_idx[3:0]] : 32'h0;
        rresp_q  <= ar_map ? RESP_OK : RESP_ERR;
      end else if (rvalid_q && s_axi.rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign tx_bit = tx_act_q[cnt_q];

  // ---------------- per-lane transmit / receive ----------------
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [9:0] sr_q;
    logic [4:0] tmr_q;
    logic       txp_q, txn_q;

    always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
        sr_q  <= '0;
        tmr_q <= '0;
        txp_q <= 1'b0;
        txn_q <= 1'b1;
      end else begin
        // newest bit enters at the top so an aligned LSB-first word reads back as-is
        sr_q <= {rxp_s2_q[i], sr_q[9:1]};
        if (sr_q == tx_act_q)
          tmr_q <= 5'd20;
        else if (tmr_q != 5'd0)
          tmr_q <= tmr_q - 5'd1;
        if (!lb_n_q[i]) begin
          txp_q <= rxp_s2_q[i];
          txn_q <= rxn_s2_q[i];
        end else begin
          txp_q <= tx_bit;
          txn_q <= ~tx_bit;
        end
      end
    end

    assign txp_w[i]   = txp_q;
    assign txn_w[i]   = txn_q;
    assign rx_sync[i] = (tmr_q != 5'd0);
  end

  // ---------------- outputs ----------------
  assign s_axi.awready = awready_q;
  assign s_axi.wready  = awready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;

  assign sgmii_port_0_txp = txp_w[0];
  assign sgmii_port_0_txn = txn_w[0];
  assign sgmii_port_1_txp = txp_w[1];
  assign sgmii_port_1_txn = txn_w[1];
  assign sgmii_port_2_txp = txp_w[2];
  assign sgmii_port_2_txn = txn_w[2];
  assign sgmii_port_3_txp = txp_w[3];
  assign sgmii_port_3_txn = txn_w[3];

  assign reset_port_0_n = prst_n_q[0];
  assign reset_port_1_n = prst_n_q[1];
  assign reset_port_2_n = prst_n_q[2];
  assign reset_port_3_n = prst_n_q[3];

  assign phy_gpio_o = gpo_q;
  assign phy_gpio_t = gpt_q;
  assign BT_rtsn    = rtsn_q;
endmodule

// File: tb/tb_axi_eth_v1_wrapper.sv
// Directed bench for axi_eth_v1_wrapper: AXI register accesses checked through
// an expected-response queue, transmit lanes checked every cycle against a
// small reference counter/word model, loopback checked through a bit queue.
module tb_axi_eth_v1_wrapper;
  localparam logic [1:0] OK  = 2'b00;
  localparam logic [1:0] ERR = 2'b10;

  logic aclk = 1'b0;
  logic arst = 1'b0;
  always #5 aclk = ~aclk;

  axi_eth_v1_wrapper_if s_axi();

  logic [3:0] rxp, rxn, txp, txn, rst_n;
  logic [7:0] gpo, gpt, gpi;
  logic       ctsn, rtsn;
  logic       xsel, lb_bit;

  // port0 <-> port2 cross-connect; port0 rx can be taken over by the bench
  assign rxp = {1'b0, txp[0], 1'b0, xsel ? lb_bit  : txp[2]};
  assign rxn = {1'b1, txn[0], 1'b1, xsel ? ~lb_bit : txn[2]};

  axi_eth_v1_wrapper dut (
    .aclk(aclk), .arst(arst), .s_axi(s_axi),
    .sgmii_port_0_rxp(rxp[0]), .sgmii_port_0_rxn(rxn[0]),
    .sgmii_port_1_rxp(rxp[1]), .sgmii_port_1_rxn(rxn[1]),
    .sgmii_port_2_rxp(rxp[2]), .sgmii_port_2_rxn(rxn[2]),
    .sgmii_port_3_rxp(rxp[3]), .sgmii_port_3_rxn(rxn[3]),
    .sgmii_port_0_txp(txp[0]), .sgmii_port_0_txn(txn[0]),
    .sgmii_port_1_txp(txp[1]), .sgmii_port_1_txn(txn[1]),
    .sgmii_port_2_txp(txp[2]), .sgmii_port_2_txn(txn[2]),
    .sgmii_port_3_txp(txp[3]), .sgmii_port_3_txn(txn[3]),
    .reset_port_0_n(rst_n[0]), .reset_port_1_n(rst_n[1]),
    .reset_port_2_n(rst_n[2]), .reset_port_3_n(rst_n[3]),
    .phy_gpio_o(gpo), .phy_gpio_t(gpt), .phy_gpio_i(gpi),
    .BT_ctsn(ctsn), .BT_rtsn(rtsn)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- transmitter reference ----------------
  logic [9:0] txw_m = 10'h0FA;
  logic [9:0] act_m;
  logic [3:0] cnt_m;
  logic       exp_tx;
  logic [3:0] lb_m = 4'hF;
  logic       mon_en = 1'b0;

  always @(posedge aclk or posedge arst) begin
    if (arst) begin
      cnt_m  <= 4'd0;
      act_m  <= 10'h0FA;
      exp_tx <= 1'b0;
    end else begin
      exp_tx <= act_m[cnt_m];
      if (cnt_m == 4'd9) begin
        cnt_m <= 4'd0;
        act_m <= txw_m;
      end else begin
        cnt_m <= cnt_m + 4'd1;
      end
    end
  end

  always @(negedge aclk) begin
    if (mon_en) begin
      for (int p = 0; p < 4; p++) begin
        if (lb_m[p]) begin
          chk($sformatf("tx%0d_p", p), {31'b0, txp[p]}, {31'b0, exp_tx});
          chk($sformatf("tx%0d_n", p), {31'b0, txn[p]}, {31'b0, ~exp_tx});
        end
      end
    end
  end

  // ---------------- AXI scoreboard ----------------
  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    string       tag;
  } exp_t;
  exp_t sbq[$];

  task automatic axi_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic [1:0] er, input string tag);
    exp_t e;
    int   n;
    @(posedge aclk); #1;
    s_axi.awaddr = a; s_axi.wdata = d; s_axi.wstrb = s;
    s_axi.awvalid = 1'b1; s_axi.wvalid = 1'b1;
    e.data = 32'h0; e.resp = er; e.tag = tag;
    sbq.push_back(e);
    n = 0;
    do begin @(negedge aclk); n++; end while (!(s_axi.awready && s_axi.wready) && n < 20);
    chk({tag, "_awready"}, {31'b0, s_axi.awready & s_axi.wready}, 32'd1);
    @(posedge aclk); #1;
    s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0;
    n = 0;
    do begin @(negedge aclk); n++; end while (!s_axi.bvalid && n < 20);
    e = sbq.pop_front();
    chk({e.tag, "_bvalid"}, {31'b0, s_axi.bvalid}, 32'd1);
    chk({e.tag, "_bresp"}, {30'b0, s_axi.bresp}, {30'b0, e.resp});
  endtask

  task automatic axi_rd(input logic [7:0] a, input logic [31:0] ed, input logic [1:0] er,
                        input string tag);
    exp_t e;
    int   n;
    @(posedge aclk); #1;
    s_axi.araddr = a; s_axi.arvalid = 1'b1;
    e.data = ed; e.resp = er; e.tag = tag;
    sbq.push_back(e);
    n = 0;
    do begin @(negedge aclk); n++; end while (!s_axi.arready && n < 20);
    chk({tag, "_arready"}, {31'b0, s_axi.arready}, 32'd1);
    @(posedge aclk); #1;
    s_axi.arvalid = 1'b0;
    n = 0;
    do begin @(negedge aclk); n++; end while (!s_axi.rvalid && n < 20);
    e = sbq.pop_front();
    chk({e.tag, "_rvalid"}, {31'b0, s_axi.rvalid}, 32'd1);
    chk({e.tag, "_rdata"}, s_axi.rdata, e.data);
    chk({e.tag, "_rresp"}, {30'b0, s_axi.rresp}, {30'b0, e.resp});
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_rst_n"}, {28'b0, rst_n}, 32'h0);
    chk({tag, "_txp"}, {28'b0, txp}, 32'h0);
    chk({tag, "_txn"}, {28'b0, txn}, 32'hF);
    chk({tag, "_gpo"}, {24'b0, gpo}, 32'h00);
    chk({tag, "_gpt"}, {24'b0, gpt}, 32'hFF);
    chk({tag, "_rtsn"}, {31'b0, rtsn}, 32'd1);
    chk({tag, "_valids"}, {28'b0, s_axi.awready, s_axi.bvalid, s_axi.arready, s_axi.rvalid}, 32'h0);
  endtask

  logic lbq[$];
  logic b;

  initial begin
    s_axi.awaddr = '0; s_axi.awvalid = 1'b0; s_axi.wdata = '0; s_axi.wstrb = '0;
    s_axi.wvalid = 1'b0; s_axi.bready = 1'b1; s_axi.araddr = '0; s_axi.arvalid = 1'b0;
    s_axi.rready = 1'b1;
    gpi = 8'h00; ctsn = 1'b0; xsel = 1'b0; lb_bit = 1'b0;

    // reset, then cross-connected sync acquisition
    #2 arst = 1'b1;
    repeat (3) @(posedge aclk);
    #1 chk_reset_outs("reset");
    arst = 1'b0;
    mon_en = 1'b1;
    repeat (30) @(posedge aclk);
    axi_rd(8'h04, 32'h0000_0005, OK, "status_sync");
    axi_rd(8'h00, 32'h4554_0001, OK, "id");
    axi_rd(8'h08, 32'h0000_000F, OK, "loopback_rst");
    axi_rd(8'h10, 32'h0000_00FA, OK, "txword_rst");
    axi_rd(8'h18, 32'h0000_00FF, OK, "gpio_t_rst");
    axi_rd(8'h20, 32'h0000_0001, OK, "uart_rst");

    // new TX_WORD: sync reacquired on the new pattern
    axi_wr(8'h10, 32'h0000_03FF, 4'hF, OK, "txword_3ff");
    txw_m = 10'h3FF;
    repeat (40) @(posedge aclk);
    axi_rd(8'h04, 32'h0000_0005, OK, "status_3ff");
    axi_rd(8'h10, 32'h0000_03FF, OK, "txword_rd");

    // byte-strobe write: only byte 0 of TX_WORD changes
    axi_wr(8'h10, 32'h0000_02B5, 4'b0001, OK, "txword_strb");
    txw_m = 10'h3B5;
    axi_rd(8'h10, 32'h0000_03B5, OK, "txword_strb_rd");
    repeat (35) @(posedge aclk);
    axi_rd(8'h04, 32'h0000_0005, OK, "status_3b5");

    // GPIO and UART flow control
    axi_wr(8'h14, 32'h0000_00A5, 4'hF, OK, "gpo_wr");
    chk("gpo_pin", {24'b0, gpo}, 32'hA5);
    axi_wr(8'h14, 32'h0000_00FF, 4'b1110, OK, "gpo_nostrb");
    chk("gpo_pin_nostrb", {24'b0, gpo}, 32'hA5);
    axi_wr(8'h18, 32'h0000_000F, 4'b0001, OK, "gpt_wr");
    chk("gpt_pin", {24'b0, gpt}, 32'h0F);
    gpi = 8'h3C;
    repeat (4) @(posedge aclk);
    axi_rd(8'h1C, 32'h0000_003C, OK, "gpio_in");
    ctsn = 1'b1;
    axi_wr(8'h20, 32'h0, 4'hF, OK, "uart_wr0");
    repeat (5) @(negedge aclk);
    chk("rtsn_cts1", {31'b0, rtsn}, 32'd1);
    axi_rd(8'h04, 32'h0000_0105, OK, "status_cts");
    ctsn = 1'b0;
    repeat (5) @(negedge aclk);
    chk("rtsn_cts0", {31'b0, rtsn}, 32'd0);
    axi_wr(8'h20, 32'h1, 4'hF, OK, "uart_wr1");
    repeat (3) @(negedge aclk);
    chk("rtsn_uart1", {31'b0, rtsn}, 32'd1);

    // line loopback on port 0: txp follows rxp three cycles later
    axi_wr(8'h08, 32'h0000_000E, 4'hF, OK, "lb_wr");
    lb_m = 4'hE;
    xsel = 1'b1;
    for (int k = 0; k < 24; k++) begin
      @(posedge aclk); #1;
      lb_bit = 1'($urandom_range(0, 1));
      lbq.push_back(lb_bit);
      @(negedge aclk);
      if (lbq.size() == 4) begin
        b = lbq.pop_front();
        chk("lb_txp", {31'b0, txp[0]}, {31'b0, b});
        chk("lb_txn", {31'b0, txn[0]}, {31'b0, ~b});
      end
    end

    // error responses, no state change
    axi_wr(8'h40, 32'hFFFF_FFFF, 4'hF, ERR, "wr_unmapped");
    axi_rd(8'h40, 32'h0, ERR, "rd_unmapped");
    axi_wr(8'h24, 32'hFFFF_FFFF, 4'hF, ERR, "wr_0x24");
    axi_rd(8'h24, 32'h0, ERR, "rd_0x24");
    axi_wr(8'h00, 32'h0, 4'hF, ERR, "wr_id");
    axi_rd(8'h00, 32'h4554_0001, OK, "id_kept");
    axi_wr(8'h1C, 32'h0, 4'hF, ERR, "wr_gpio_in");
    axi_rd(8'h08, 32'h0000_000E, OK, "loopback_kept");
    chk("gpo_kept", {24'b0, gpo}, 32'hA5);

    // port resets, then reset during an in-flight read
    axi_wr(8'h0C, 32'h0000_0005, 4'hF, OK, "prst_wr");
    chk("prst_pins", {28'b0, rst_n}, 32'h5);
    @(posedge aclk); #1;
    s_axi.araddr = 8'h00; s_axi.arvalid = 1'b1;
    @(posedge aclk);
    @(posedge aclk); #2;
    arst = 1'b1; txw_m = 10'h0FA; lb_m = 4'hF; xsel = 1'b0;
    #1 chk_reset_outs("midread");
    @(posedge aclk); #1;
    s_axi.arvalid = 1'b0;
    repeat (2) @(posedge aclk);
    #1 arst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge aclk);
      chk("no_stale_rvalid", {31'b0, s_axi.rvalid}, 32'd0);
    end
    axi_rd(8'h08, 32'h0000_000F, OK, "loopback_after_rst");
    axi_rd(8'h0C, 32'h0000_0000, OK, "prst_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
